// File: rtl/falafel_alloc_req_fifo.sv
// Request FIFO between the input arbiter and the allocator core.
// Holds {size, id} allocation requests and presents the oldest one
// first-word-fall-through on a valid/ready port. Occupancy, full and
// overflow come from registered state only, so the arbiter can sample
// full_o in the same cycle it drives write_i.
module falafel_alloc_req_fifo #(
    parameter int DEPTH       = 4,
    parameter int DATA_W      = 32,
    parameter int MSG_ID_SIZE = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   write_i,
    input  logic [DATA_W-1:0]      din_size_i,
    input  logic [MSG_ID_SIZE-1:0] din_id_i,
    output logic                   full_o,
    output logic                   req_val_o,
    input  logic                   req_rdy_i,
    output logic [DATA_W-1:0]      req_size_o,
    output logic [MSG_ID_SIZE-1:0] req_id_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + MSG_ID_SIZE;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          push;
    logic          pop;
    logic          full;

    // Full and valid derive from the registered count only; a write while
    // full is dropped even when a pop happens in the same cycle.
    assign full      = (count == CW'(DEPTH));
    assign push      = write_i && !full;
    assign pop       = req_val_o && req_rdy_i;
    assign req_val_o = (count != '0);
    assign full_o    = full;
    assign count_o   = count;
    assign overflow_o = overflow;

    // Head entry is read straight out of storage (fall-through).
    assign {req_size_o, req_id_o} = mem[rd_ptr];

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {din_size_i, din_id_i};
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (write_i && full) begin
                overflow <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    // Simulation-only sanity checks on occupancy and the dropped-write case.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (write_i && full) begin
                $warning("alloc req fifo: write while full, request dropped");
            end
            assert (count <= CW'(DEPTH))
                else $error("alloc req fifo: count exceeds depth");
            assert (req_val_o == (count_o != '0))
                else $error("alloc req fifo: valid disagrees with count");
        end
    end
`endif

endmodule

// File: tb/tb_falafel_alloc_req_fifo.sv
// Bench for falafel_alloc_req_fifo: directed scenarios followed by random
// traffic, checked against a queue-based model through a scoreboard.
module tb_falafel_alloc_req_fifo;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int IW    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          write_i = 1'b0;
    logic [DW-1:0] din_size_i = '0;
    logic [IW-1:0] din_id_i = '0;
    logic          full_o;
    logic          req_val_o;
    logic          req_rdy_i = 1'b0;
    logic [DW-1:0] req_size_o;
    logic [IW-1:0] req_id_o;
    logic [CW-1:0] count_o;
    logic          overflow_o;

    falafel_alloc_req_fifo #(
        .DEPTH(DEPTH),
        .DATA_W(DW),
        .MSG_ID_SIZE(IW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .write_i(write_i),
        .din_size_i(din_size_i),
        .din_id_i(din_id_i),
        .full_o(full_o),
        .req_val_o(req_val_o),
        .req_rdy_i(req_rdy_i),
        .req_size_o(req_size_o),
        .req_id_o(req_id_o),
        .count_o(count_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of pending requests plus a sticky flag.
    logic [DW+IW-1:0] model_q [$];
    logic             model_ovf = 1'b0;
    // Expected handshake results for the current cycle.
    logic [DW+IW-1:0] exp_q [$];
    // Snapshot of the model's registered state for the current cycle.
    int               cur_count = 0;
    logic             cur_ovf = 1'b0;
    logic [DW+IW-1:0] cur_head = '0;
    logic             chk_en = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic snapshot();
        cur_count = model_q.size();
        cur_ovf   = model_ovf;
        cur_head  = (model_q.size() != 0) ? model_q[0] : '0;
    endtask

    // One bus cycle: drive inputs and advance the model by the same rules.
    task automatic cyc(input logic w, input logic [DW-1:0] s, input logic [IW-1:0] id,
                       input logic r);
        @(posedge clk);
        #1;
        snapshot();
        rst_i      = 1'b0;
        write_i    = w;
        din_size_i = s;
        din_id_i   = id;
        req_rdy_i  = r;
        begin
            bool_step(w, {s, id}, r);
        end
    endtask

    task automatic bool_step(input logic w, input logic [DW+IW-1:0] e, input logic r);
        bit was_full;
        was_full = (model_q.size() == DEPTH);
        if (r && model_q.size() != 0) begin
            exp_q.push_back(model_q.pop_front());
        end
        if (w && !was_full) begin
            model_q.push_back(e);
        end
        if (w && was_full) begin
            model_ovf = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        snapshot();
        rst_i     = 1'b1;
        write_i   = 1'b0;
        req_rdy_i = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0);
    endtask

    // Monitor: mid-cycle, compare registered outputs with the model snapshot
    // and consume an expected entry for every handshake the DUT presents.
    always @(negedge clk) begin
        if (chk_en && !rst_i) begin
            check("count", count_o, cur_count);
            check("full", full_o, cur_count == DEPTH);
            check("valid", req_val_o, cur_count != 0);
            check("overflow", overflow_o, cur_ovf);
            if (req_val_o && cur_count != 0) begin
                check("head", {req_size_o, req_id_o}, cur_head);
            end
            if (req_val_o && req_rdy_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 1, 0);
                end else begin
                    check("pop_data", {req_size_o, req_id_o}, exp_q.pop_front());
                end
            end else if (exp_q.size() != 0) begin
                check("missing_pop", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        do_reset();
        chk_en = 1'b1;

        // Single entry, then pop it.
        cyc(1'b1, 32'h40, 8'd3, 1'b0);
        cyc(1'b0, '0, '0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1);
        idle(2);

        // Fill, overflow attempt, drain.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100 + i, 8'(i), 1'b0);
        cyc(1'b1, 32'h104, 8'd4, 1'b0);
        idle(2);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, '0, 1'b1);
        idle(1);

        // Full with simultaneous push and pop: write dropped.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h200 + i, 8'(10 + i), 1'b0);
        cyc(1'b1, 32'h209, 8'd9, 1'b1);
        idle(1);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b1);
        idle(1);

        // Streaming across pointer wrap.
        for (int i = 0; i < 20; i++) cyc(1'b1, 32'h300 + i, 8'(i), 1'b1);
        cyc(1'b0, '0, '0, 1'b1);
        idle(1);

        // Pops while empty, then a single push.
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1);
        cyc(1'b1, 32'h77, 8'd7, 1'b0);
        cyc(1'b0, '0, '0, 1'b1);
        idle(1);

        // Mid-stream reset with entries held and overflow set.
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h500 + i, 8'(20 + i), 1'b0);
        cyc(1'b0, '0, '0, 1'b1);
        idle(1);
        do_reset();
        idle(1);
        cyc(1'b1, 32'h55, 8'd5, 1'b0);
        cyc(1'b0, '0, '0, 1'b1);
        idle(1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cyc(1'($urandom_range(0, 99) < 60), 32'($urandom), 8'($urandom),
                    1'($urandom_range(0, 99) < 50));
            end
        end
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, '0, '0, 1'b1);
        idle(2);

        check("leftover_expected", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
